// File: rtl/microseq.sv
// Microprogram sequencer: selects the next control-store address from
// sequential, branch, decode, subroutine and loop sources.
module microseq #(
    parameter int AW      = 5,
    parameter int CCW     = 4,
    parameter int DEPTH   = 4,
    parameter int CW      = 8,
    parameter int RSTADDR = 0,
    localparam int CSW    = (CCW > 1) ? $clog2(CCW) : 1,
    localparam int SPW    = $clog2(DEPTH + 1)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           stall,
    input  logic [2:0]     nssel,
    input  logic [AW-1:0]  ib,
    input  logic [AW-1:0]  sb,
    input  logic [AW-1:0]  db,
    input  logic [CSW-1:0] ccsel,
    input  logic [CCW-1:0] cc,
    input  logic           ccpol,
    input  logic           ldcnt,
    input  logic [CW-1:0]  cntin,
    output logic [AW-1:0]  nextst,
    output logic [CW-1:0]  loopcnt,
    output logic [SPW-1:0] sp,
    output logic           stkerr
);

    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NCC = 1 << CSW;

    typedef enum logic [2:0] {
        NS_SEQ, NS_JMP, NS_IB, NS_SB, NS_BRC, NS_CALL, NS_RET, NS_LOOP
    } ns_mode_t;

    logic [AW-1:0]  stack [1 << IW];
    logic [NCC-1:0] cc_ext;
    logic           cond;
    logic [AW-1:0]  inc;
    logic [AW-1:0]  nxt;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           err_set;
    logic           dec;
    ns_mode_t       mode;

    // Zero-extending cc makes unused selector codes read as a clear condition.
    assign cc_ext = NCC'(cc);
    assign cond   = cc_ext[ccsel] ^ ccpol;
    assign inc    = nextst + AW'(1);
    assign full   = (sp == SPW'(DEPTH));
    assign empty  = (sp == '0);
    assign mode   = ns_mode_t'(nssel);

    always_comb begin
        nxt     = inc;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        dec     = 1'b0;
        case (mode)
            NS_SEQ:  nxt = inc;
            NS_JMP:  nxt = db;
            NS_IB:   nxt = ib;
            NS_SB:   nxt = sb;
            NS_BRC:  nxt = cond ? db : inc;
            NS_CALL: begin
                nxt = db;
                if (full) err_set = 1'b1;
                else      push    = 1'b1;
            end
            NS_RET: begin
                if (empty) begin
                    nxt     = AW'(RSTADDR);
                    err_set = 1'b1;
                end else begin
                    nxt = stack[IW'(sp - SPW'(1))];
                    pop = 1'b1;
                end
            end
            NS_LOOP: begin
                if (loopcnt != '0) begin
                    nxt = db;
                    dec = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            nextst  <= AW'(RSTADDR);
            sp      <= '0;
            loopcnt <= '0;
            stkerr  <= 1'b0;
        end else if (!stall) begin
            nextst <= nxt;
            if (push)     sp <= sp + SPW'(1);
            else if (pop) sp <= sp - SPW'(1);
            if (err_set)  stkerr <= 1'b1;
            // A load wins over the loop decrement; the branch already used the old count.
            if (ldcnt)    loopcnt <= cntin;
            else if (dec) loopcnt <= loopcnt - CW'(1);
        end
    end

    // Stack entries are not reset; nothing reads them while sp is zero.
    always_ff @(posedge clock) begin
        if (!reset && !stall && push)
            stack[IW'(sp)] <= inc;
    end

endmodule

// File: doc/microseq.md
MICROSEQ -- requirements
Module: microseq

Interface
REQ-001 SHALL have parameter AW, default 5: microaddress width (ib, sb, db, nextst).
REQ-002 SHALL have parameter CCW, default 4: number of condition-code inputs; CSW = max(1, clog2(CCW)).
REQ-003 SHALL have parameter DEPTH, default 4: subroutine return-stack entries, DEPTH >= 1.
REQ-004 SHALL have parameter CW, default 8: loop-counter width.
REQ-005 SHALL have parameter RSTADDR, default 0: microaddress loaded on reset and on stack underflow.
REQ-006 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port stall, input, 1: when 1, holds all state except the reset effect.
REQ-009 SHALL have port nssel, input, 3: next-state mode select (REQ-016).
REQ-010 SHALL have ports ib, sb, db, input, AW each: instruction-decode base, secondary base, and microword direct-branch address.
REQ-011 SHALL have ports ccsel (input, CSW), cc (input, CCW) and ccpol (input, 1): condition select, condition vector, and condition polarity (1 = branch on cc clear).
REQ-012 SHALL have ports ldcnt (input, 1) and cntin (input, CW): loop-counter load strobe and load value.
REQ-013 SHALL have port nextst, output, AW: registered current microaddress, driving the control-store address.
REQ-014 SHALL have ports loopcnt (output, CW), sp (output, clog2(DEPTH+1)) and stkerr (output, 1): loop count, stack occupancy, and sticky stack error.

Function
REQ-015 SHALL compute inc = (nextst + 1) mod 2^AW; for example, 31 wraps to 0 when AW = 5.
REQ-016 SHALL select the next address by nssel, with cond = cc[ccsel] XOR ccpol:
  - 000 SEQ: inc.
  - 001 JMP: db.
  - 010 IB: ib.
  - 011 SB: sb.
  - 100 BRC: cond ? db : inc.
  - 101 CALL: db, and push inc.
  - 110 RET: pop the top of stack.
  - 111 LOOP: loopcnt != 0 ? db with loopcnt decremented : inc.
REQ-017 SHALL register the selected address into nextst at the rising edge when stall = 0, giving 1-cycle latency from inputs to nextst.
REQ-018 SHALL, when ccsel >= CCW, treat cc[ccsel] as 0.
REQ-019 SHALL implement the return stack as LIFO: push writes entry sp and then increments sp; pop reads entry sp-1 and then decrements sp.
REQ-020 SHALL handle CALL with sp = DEPTH as follows: no push, sp unchanged, stkerr set to 1, jump to db still taken.
REQ-021 SHALL handle RET with sp = 0 as follows: no pop, stkerr set to 1, nextst set to RSTADDR.
REQ-022 SHALL keep stkerr set until reset.
REQ-023 SHALL, when ldcnt = 1 and stall = 0, load loopcnt with cntin.
REQ-024 SHALL, when ldcnt and LOOP occur in the same cycle, make the branch decision from the pre-load loopcnt, and the load SHALL override the decrement.
REQ-025 SHALL, in LOOP mode with loopcnt = 0, fall through to inc with loopcnt held at 0 (no underflow wrap).
REQ-026 SHALL, when stall = 1, leave nextst, the stack, sp, loopcnt and stkerr unchanged and ignore ldcnt.
REQ-027 SHALL produce no combinational path from any input to any output.

Reset
REQ-028 SHALL, at the rising edge with reset = 1, set nextst to RSTADDR and sp, loopcnt and stkerr to 0; reset SHALL override stall, ldcnt and all modes.
REQ-029 SHALL, when reset is asserted mid-subroutine or mid-loop, discard all stack contents and counts; the next cycle after reset deasserts SHALL resume from RSTADDR.
REQ-030 SHALL not require stack entries to be cleared on reset; their contents SHALL be unobservable while sp = 0.

Verification
REQ-031 SHALL cover sequencing: reset, then 33 cycles of SEQ (AW = 5) -> nextst goes 0,1,...,31,0,1; sp, loopcnt and stkerr all 0.
REQ-032 SHALL cover branching: at nextst = 3, BRC with ccsel = 2, cc = 0100, ccpol = 0, db = 20 -> nextst = 20. The same case with ccpol = 1 -> nextst = 4. Then IB with ib = 9 -> nextst = 9.
REQ-033 SHALL cover nested calls: at nextst = 2, CALL db = 10, then at 10, CALL db = 16, then RET, then RET -> nextst = 10, 16, 11, 3; sp = 1, 2, 1, 0; stkerr stays 0.
REQ-034 SHALL cover stack error: with DEPTH = 4, perform 5 consecutive CALLs -> sp saturates at 4, stkerr = 1 after the 5th, and the 5th jump is taken. After reset, a RET -> nextst = RSTADDR and stkerr = 1.
REQ-035 SHALL cover looping: ldcnt with cntin = 3, then LOOP db = 7 issued from address 7 repeatedly -> nextst = 7, 7, 7, then 8; loopcnt = 2, 1, 0, 0. A simultaneous ldcnt (cntin = 5) with LOOP when loopcnt = 0 -> falls through to inc and loopcnt = 5.
REQ-036 SHALL cover stall and reset overlap: stall held 3 cycles during a CALL -> nextst, sp and loopcnt frozen; asserting reset while stall = 1 -> nextst = RSTADDR and sp = 0 on the next edge.
